// File: rtl/snd_pkg.sv
// Shared types for the snake sound-event scheduler: FSM states, drop counter
// width, the after-game-over hold flag and a saturating increment helper.
package snd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRE_FOOD,
    FIRE_GO,
    HOLD,
    OVER
  } snd_state_t;

  localparam int DROP_W = 8;

  typedef logic after_go_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/snd_event_sched_rise_pulse.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a 0->1 on lvl_i.
module rise_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic lvl_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= lvl_i;
      rise_q <= lvl_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/snd_event_sched.sv
// Game-event to tone-request scheduler: queues food bites, lets game-over preempt,
// latches OVER until restart. Optional macro SND_MUTE_EN adds a mute input.
module snd_event_sched
  import snd_pkg::*;
#(
  parameter int FOOD_HOLD_CYC = 5_000_000,
  parameter int GO_HOLD_CYC   = 50_000_000,
  parameter int DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
`ifdef SND_MUTE_EN
  input  logic                       mute,
`endif
  input  logic                       evt_food,
  input  logic                       evt_game_over,
  input  logic                       evt_restart,
  output logic                       food_eaten,
  output logic                       game_over,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int TMAX = (FOOD_HOLD_CYC > GO_HOLD_CYC) ? FOOD_HOLD_CYC : GO_HOLD_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int PW   = $clog2(DEPTH+1);

  localparam logic [TW-1:0] FOOD_LOAD = TW'(FOOD_HOLD_CYC - 1);
  localparam logic [TW-1:0] GO_LOAD   = TW'(GO_HOLD_CYC - 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(DEPTH);

  logic food_rise;
  logic go_rise;
  logic restart_rise;

  rise_pulse u_food_edge (
    .clk    (clk),
    .rst_n  (reset_n),
    .lvl_i  (evt_food),
    .rise_o (food_rise)
  );

  rise_pulse u_go_edge (
    .clk    (clk),
    .rst_n  (reset_n),
    .lvl_i  (evt_game_over),
    .rise_o (go_rise)
  );

  rise_pulse u_restart_edge (
    .clk    (clk),
    .rst_n  (reset_n),
    .lvl_i  (evt_restart),
    .rise_o (restart_rise)
  );

  snd_state_t        state_q,    state_d;
  logic [TW-1:0]     timer_q,    timer_d;
  after_go_t         after_go_q, after_go_d;
  logic [PW-1:0]     pending_q,  pending_d;
  logic [DROP_W-1:0] drop_q,     drop_d;

  logic go_take;
  logic enq;
  logic deq;
  logic mute_s;

`ifdef SND_MUTE_EN
  assign mute_s = mute;
`else
  assign mute_s = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      after_go_q <= 1'b0;
      pending_q  <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      after_go_q <= after_go_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    after_go_d = after_go_q;
    pending_d  = pending_q;
    drop_d     = drop_q;
    food_eaten = 1'b0;
    game_over  = 1'b0;
    busy       = 1'b0;

    // The game-over hold itself cannot be restarted by a repeated game-over edge.
    go_take = go_rise && (state_q != FIRE_GO) && (state_q != OVER) &&
              !((state_q == HOLD) && after_go_q);
    deq     = (state_q == FIRE_FOOD);
    enq     = food_rise && !go_rise && (state_q != OVER);

    case (state_q)
      IDLE: begin
        if (pending_q != '0) state_d = FIRE_FOOD;
      end
      FIRE_FOOD: begin
        food_eaten = ~mute_s;
        busy       = 1'b1;
        timer_d    = FOOD_LOAD;
        after_go_d = 1'b0;
        state_d    = HOLD;
      end
      FIRE_GO: begin
        game_over  = ~mute_s;
        busy       = 1'b1;
        timer_d    = GO_LOAD;
        after_go_d = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        // Chain straight into the next queued bite so busy never dips mid-burst.
        if (timer_q == '0) begin
          if (after_go_q)             state_d = OVER;
          else if (pending_q != '0)   state_d = FIRE_FOOD;
          else                        state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      OVER: begin
        if (restart_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (go_take) state_d = FIRE_GO;

    if (state_q == FIRE_GO) begin
      pending_d = '0;
    end else if (enq && !deq) begin
      if (pending_q == PEND_FULL) drop_d    = sat_inc(drop_q);
      else                        pending_d = pending_q + PW'(1);
    end else if (deq && !enq) begin
      pending_d = pending_q - PW'(1);
    end
  end

  assign pending  = pending_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_snd_event_sched.sv
// Directed bench for snd_event_sched: cycle-exact vector table plus scenario sequences.
module tb_snd_event_sched;

  localparam int FH = 100;
  localparam int GH = 500;
  localparam int DP = 4;
  localparam int PW = $clog2(DP+1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          evt_food = 1'b0;
  logic          evt_game_over = 1'b0;
  logic          evt_restart = 1'b0;
  logic          food_eaten;
  logic          game_over;
  logic          busy;
  logic [PW-1:0] pending;
  logic [7:0]    drop_cnt;
`ifdef SND_MUTE_EN
  logic          mute = 1'b0;
`endif

  snd_event_sched #(
    .FOOD_HOLD_CYC (FH),
    .GO_HOLD_CYC   (GH),
    .DEPTH         (DP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
`ifdef SND_MUTE_EN
    .mute          (mute),
`endif
    .evt_food      (evt_food),
    .evt_game_over (evt_game_over),
    .evt_restart   (evt_restart),
    .food_eaten    (food_eaten),
    .game_over     (game_over),
    .busy          (busy),
    .pending       (pending),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_total = 0;
  int go_total = 0;
  int fe_times[$];
  int busy_low = 0;
  bit watch = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (food_eaten === 1'b1) begin
      fe_total++;
      fe_times.push_back(cyc);
    end
    if (game_over === 1'b1) go_total++;
    if (watch && busy !== 1'b1) busy_low++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    evt_food = 1'b0;
    evt_game_over = 1'b0;
    evt_restart = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic pulse_food();
    evt_food = 1'b1;
    step(2);
    evt_food = 1'b0;
    step(2);
  endtask

  typedef struct {
    logic f, g, r;
    logic efe, ego, ebusy;
    int   epend;
    int   edrop;
  } vec_t;

  vec_t tbl[11];
  int fe0, go0, n0;

  initial begin
    // food/go/restart inputs, then expected food_eaten, game_over, busy, pending, drop
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};

    step(2);
    chk("rst_food_eaten", food_eaten, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_drop", drop_cnt, 0);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      evt_food      = tbl[i].f;
      evt_game_over = tbl[i].g;
      evt_restart   = tbl[i].r;
      step(1);
      chk($sformatf("vec%0d_food_eaten", i), food_eaten, tbl[i].efe);
      chk($sformatf("vec%0d_game_over", i), game_over, tbl[i].ego);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].ebusy);
      chk($sformatf("vec%0d_pending", i), pending, tbl[i].epend);
      chk($sformatf("vec%0d_drop", i), drop_cnt, tbl[i].edrop);
    end

    // Single long food level: one pulse only.
    do_reset();
    fe0 = fe_total;
    evt_food = 1'b1;
    step(20);
    evt_food = 1'b0;
    step(110);
    chk("single_pulses", fe_total - fe0, 1);
    chk("single_pending", pending, 0);
    chk("single_busy", busy, 0);

    // Burst of three bites: spacing FH+1, busy held.
    do_reset();
    fe0 = fe_total;
    n0 = fe_times.size();
    for (int i = 0; i < 3; i++) begin
      evt_food = 1'b1;
      step(2);
      evt_food = 1'b0;
      step(3);
    end
    busy_low = 0;
    watch = 1'b1;
    for (int i = 0; i < 300 && (fe_total - fe0) < 3; i++) step(1);
    watch = 1'b0;
    chk("burst_pulses", fe_total - fe0, 3);
    chk("burst_busy_low", busy_low, 0);
    if (fe_times.size() >= n0 + 3) begin
      chk("burst_gap1", fe_times[n0+1] - fe_times[n0], FH + 1);
      chk("burst_gap2", fe_times[n0+2] - fe_times[n0+1], FH + 1);
    end

    // Overflow: 7 bites, 1 served at once, 4 queued, 2 dropped.
    do_reset();
    fe0 = fe_total;
    repeat (7) pulse_food();
    step(2);
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_pending", pending, DP);
    step(520);
    chk("ovf_pulses", fe_total - fe0, 5);
    chk("ovf_pending_end", pending, 0);

    // Game-over preempting a food hold with two bites queued.
    do_reset();
    fe0 = fe_total;
    go0 = go_total;
    repeat (3) pulse_food();
    step(32);
    chk("pre_pending", pending, 2);
    evt_game_over = 1'b1;
    step(1);
    chk("pre_go_early", game_over, 0);
    step(1);
    chk("pre_go_pulse", game_over, 1);
    evt_game_over = 1'b0;
    step(1);
    chk("pre_go_single", game_over, 0);
    chk("pre_pending_clr", pending, 0);
    step(499);
    chk("pre_busy_last_hold", busy, 1);
    step(1);
    chk("pre_over_busy", busy, 0);
    chk("pre_food_pulses", fe_total - fe0, 1);
    chk("pre_go_pulses", go_total - go0, 1);

    // Simultaneous food + game-over, then OVER ignores food until restart.
    do_reset();
    fe0 = fe_total;
    go0 = go_total;
    evt_food = 1'b1;
    evt_game_over = 1'b1;
    step(2);
    chk("sim_go_pulse", game_over, 1);
    chk("sim_no_food", food_eaten, 0);
    evt_food = 1'b0;
    evt_game_over = 1'b0;
    step(5);
    chk("sim_drop", drop_cnt, 0);
    chk("sim_pending", pending, 0);
    step(500);
    chk("over_busy", busy, 0);
    pulse_food();
    step(6);
    chk("over_food_pending", pending, 0);
    chk("over_food_drop", drop_cnt, 0);
    chk("over_food_pulses", fe_total - fe0, 0);
    evt_restart = 1'b1;
    step(2);
    evt_restart = 1'b0;
    step(1);
    pulse_food();
    step(4);
    chk("restart_food_pulses", fe_total - fe0, 1);
    chk("sim_go_pulses", go_total - go0, 1);

    // Asynchronous reset in the middle of a hold.
    do_reset();
    repeat (7) pulse_food();
    step(20);
    chk("areset_pre_drop", drop_cnt, 2);
    #3;
    reset_n = 1'b0;
    #1;
    chk("areset_busy", busy, 0);
    chk("areset_pending", pending, 0);
    chk("areset_drop", drop_cnt, 0);
    chk("areset_food", food_eaten, 0);
    chk("areset_go", game_over, 0);
    step(3);
    reset_n = 1'b1;
    fe0 = fe_total;
    go0 = go_total;
    step(200);
    chk("areset_no_food", fe_total - fe0, 0);
    chk("areset_no_go", go_total - go0, 0);
    chk("areset_idle", busy, 0);

    // Drop counter saturation.
    do_reset();
    repeat (300) pulse_food();
    chk("drop_saturate", drop_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
